// File: rtl/rx_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rx_packet_arbiter
// Description : Merges N_PORTS serial receiver streams onto one downstream
//               packet path. Each port owns a one-entry holding slot; a
//               round-robin arbiter moves held packets into a registered
//               output stage guarded by a valid/accept handshake.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               rx_packet/rx_ready  - per-port packet slices + 1-cycle strobes
//               out_packet/out_port - granted packet and its source port
//               out_valid/out_accept- output handshake
//               overflow            - sticky per-port drop flags
//               overflow_clr        - clears all overflow flags
// Revision    : 1.0 - initial release
// ============================================================================
module rx_packet_arbiter #(
    parameter int N_PORTS = 4,
    parameter int PKT_W   = 55,
    parameter int PORT_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PORTS*PKT_W-1:0]   rx_packet,
    input  logic [N_PORTS-1:0]         rx_ready,
    output logic [PKT_W-1:0]           out_packet,
    output logic [PORT_W-1:0]          out_port,
    output logic                       out_valid,
    input  logic                       out_accept,
    output logic [N_PORTS-1:0]         overflow,
    input  logic                       overflow_clr
);

    logic [PKT_W-1:0]   w_rx_pkt [N_PORTS];

    logic [PKT_W-1:0]   r_slot [N_PORTS];
    logic [N_PORTS-1:0] r_pending;
    logic [PORT_W-1:0]  r_rr_ptr;
    logic [PKT_W-1:0]   r_out_packet;
    logic [PORT_W-1:0]  r_out_port;
    logic               r_out_valid;
    logic [N_PORTS-1:0] r_overflow;

    logic               w_load_ok;
    logic               w_grant_valid;
    logic [PORT_W-1:0]  w_grant_idx;
    logic [N_PORTS-1:0] w_drain;
    logic [N_PORTS-1:0] w_capture;
    logic [N_PORTS-1:0] w_drop;

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_slice
            assign w_rx_pkt[gi] = rx_packet[gi*PKT_W +: PKT_W];
        end
    endgenerate

    // Output stage can take a new packet when empty or being emptied now.
    assign w_load_ok = !r_out_valid || out_accept;

    // Round-robin search starting just after the last granted port.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            if (!w_grant_valid && w_load_ok &&
                r_pending[(int'(r_rr_ptr) + k) % N_PORTS]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = PORT_W'((int'(r_rr_ptr) + k) % N_PORTS);
            end
        end
    end

    // A slot being drained this cycle may accept a new packet at the same
    // edge; only a full, non-draining slot drops.
    always_comb begin
        w_drain   = '0;
        w_capture = '0;
        w_drop    = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_drain[i]   = w_grant_valid && (w_grant_idx == PORT_W'(i));
            w_capture[i] = rx_ready[i] && (!r_pending[i] || w_drain[i]);
            w_drop[i]    = rx_ready[i] && r_pending[i] && !w_drain[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= '0;
            r_rr_ptr     <= PORT_W'(N_PORTS - 1);
            r_out_packet <= '0;
            r_out_port   <= '0;
            r_out_valid  <= 1'b0;
            r_overflow   <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            if (w_grant_valid) begin
                r_out_packet <= r_slot[w_grant_idx];
                r_out_port   <= w_grant_idx;
                r_out_valid  <= 1'b1;
                r_rr_ptr     <= w_grant_idx;
            end else if (r_out_valid && out_accept) begin
                r_out_valid  <= 1'b0;
            end

            for (int i = 0; i < N_PORTS; i++) begin
                if (w_capture[i]) begin
                    r_slot[i]    <= w_rx_pkt[i];
                    r_pending[i] <= 1'b1;
                end else if (w_drain[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end

            // A drop in the same cycle as a clear keeps the flag set.
            r_overflow <= (r_overflow & ~{N_PORTS{overflow_clr}}) | w_drop;
        end
    end

    assign out_packet = r_out_packet;
    assign out_port   = r_out_port;
    assign out_valid  = r_out_valid;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire
